// File: rtl/fc_omem_write_bridge.sv
// fc_omem_write_bridge: buffers fire-and-forget controller writes in a FWFT FIFO and drains them
// onto a valid/ready write channel, tracking run completion and sticky error flags.
module fc_omem_write_bridge #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int EXPECTED_WRITES = 301056,
    parameter int ADDR_LIMIT      = 301056
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_wr_en,
    input  logic [ADDR_W-1:0]             in_addr,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          ctrl_done,
    output logic                          m_valid,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [DATA_W-1:0]             m_data,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [19:0]                   issued_cnt,
    output logic                          overflow_err,
    output logic                          addr_err,
    output logic                          count_err,
    output logic                          run_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, FLUSHED} state_t;
    state_t state;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [ADDR_W+DATA_W-1:0] mem [FIFO_DEPTH];
    logic empty, full, live, in_range, pop, push;
    always_comb begin
        empty      = wr_ptr == rd_ptr;
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        live       = (state == ACTIVE || state == DRAIN) && !start;
        in_range   = in_addr < ADDR_W'(ADDR_LIMIT);
        m_valid    = !empty;
        pop        = m_valid && m_ready;
        push       = live && in_wr_en && in_range && (!full || pop);
        {m_addr, m_data} = empty ? '0 : mem[rd_ptr[AW-1:0]];
        fifo_level = wr_ptr - rd_ptr;
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= {in_addr, in_data};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            issued_cnt   <= '0;
            overflow_err <= 1'b0;
            addr_err     <= 1'b0;
            count_err    <= 1'b0;
            run_done     <= 1'b0;
        end else if (start) begin
            state        <= ACTIVE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            issued_cnt   <= '0;
            overflow_err <= 1'b0;
            addr_err     <= 1'b0;
            count_err    <= 1'b0;
            run_done     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (pop && !(&issued_cnt)) issued_cnt <= issued_cnt + 20'd1;
            if (live && in_wr_en && !in_range) addr_err <= 1'b1;
            if (live && in_wr_en && in_range && full && !pop) overflow_err <= 1'b1;
            // a strobe landing on an empty FIFO keeps the run open one more cycle
            if (state == ACTIVE && ctrl_done) state <= DRAIN;
            if (state == DRAIN && empty && !push) begin
                state     <= FLUSHED;
                run_done  <= 1'b1;
                count_err <= issued_cnt != 20'(EXPECTED_WRITES);
            end
        end
    end
endmodule
